// File: rtl/unison_capture_pkg.sv
// Shared types and constants for the unison readout capture block.
// Sample, word and length widths plus the capture FSM state encoding.
package unison_capture_pkg;

    localparam int NIB_W            = 4;
    localparam int WORD_W           = 32;
    localparam int SAMPLES_PER_WORD = 8;
    localparam int LEN_W            = 16;
    localparam int IDX_W            = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/unison_sync_fifo.sv
// Single-clock show-ahead FIFO for packed readout words.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module unison_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int WORD_W = 32,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       level
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              wr;
    logic              rd;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign rd      = pop && !empty;
    assign wr      = push && (!full || rd);
    assign rd_data = empty ? '0 : mem[rptr];

    // Storage write; suppressed on a reset edge so nothing lands.
    always_ff @(posedge clk) begin
        if (rstb && wr) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks net push/pop.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (rd) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({wr, rd})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/unison_readout_capture.sv
// Captures I/Q readout nibbles from one digital_unison instance,
// packs eight per 32-bit word and queues the words for the host.
module unison_readout_capture #(
    parameter int DEPTH            = 8,
    parameter int SAMPLES_PER_WORD = 8
) (
    input  logic        clk_master,
    input  logic        rstb,
    input  logic        start,
    input  logic [15:0] capture_len,
    input  logic [1:0]  read_out_I,
    input  logic [1:0]  read_out_Q,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [4:0]  level
);

    import unison_capture_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int SH_W = WORD_W - NIB_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_WORD - 1);

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_cnt;
    logic [LEN_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  samp_idx;
    logic [SH_W-1:0]   shreg;
    logic [NIB_W-1:0]  nib;
    logic [WORD_W-1:0] push_word;
    logic              capturing;
    logic              start_ok;
    logic              word_done;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_level;

    assign nib       = {read_out_I, read_out_Q};
    assign capturing = (state == ST_CAPTURE);
    assign start_ok  = start && !capturing;
    assign word_done = capturing && (samp_idx == LAST_IDX);
    assign push_word = {nib, shreg};
    assign cnt_next  = word_cnt + LEN_W'(1);
    assign pop       = rd_en && !fifo_empty;

    assign rd_valid = !fifo_empty;
    assign busy     = capturing;
    assign done     = (state == ST_DONE);
    assign level    = 5'(fifo_level);

    // Capture FSM and nibble packer; newest nibble enters at the top.
    always_ff @(posedge clk_master) begin
        if (!rstb) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            word_cnt <= '0;
            samp_idx <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
        end else if (start_ok) begin
            len_q    <= capture_len;
            word_cnt <= '0;
            samp_idx <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
            state    <= (capture_len == '0) ? ST_DONE : ST_CAPTURE;
        end else if (capturing) begin
            samp_idx <= samp_idx + IDX_W'(1);
            if (word_done) begin
                shreg    <= '0;
                word_cnt <= cnt_next;
                if (fifo_full && !pop) begin
                    overflow <= 1'b1;
                end
                if (cnt_next == len_q) begin
                    state <= ST_DONE;
                end
            end else begin
                shreg <= {nib, shreg[SH_W-1:NIB_W]};
            end
        end
    end

    unison_sync_fifo #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_fifo (
        .clk       (clk_master),
        .rstb      (rstb),
        .push      (word_done),
        .push_data (push_word),
        .pop       (pop),
        .rd_data   (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

endmodule

// File: doc/unison_readout_capture.md
UNISON_READOUT_CAPTURE -- requirements
Module: unison_readout_capture

Interface
REQ-001 Parameter DEPTH, default 8: FIFO depth in 32-bit words; power of two, 2..16.
REQ-002 Parameter SAMPLES_PER_WORD, fixed at 8: 4-bit samples packed per word.
REQ-003 clk_master  input  1  sole clock; all state updates on its rising edge.
REQ-004 rstb  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  single-cycle capture request.
REQ-006 capture_len  input  16  number of words to capture; sampled when start is accepted.
REQ-007 read_out_I  input  2  I-channel readout from one digital_unison instance.
REQ-008 read_out_Q  input  2  Q-channel readout from the same instance.
REQ-009 rd_en  input  1  host pop request.
REQ-010 rd_data  output  32  FIFO head word, show-ahead.
REQ-011 rd_valid  output  1  FIFO not empty.
REQ-012 busy  output  1  high in CAPTURE.
REQ-013 done  output  1  high in DONE.
REQ-014 overflow  output  1  sticky; at least one word was dropped.
REQ-015 level  output  5  FIFO occupancy, 0..DEPTH.

Function
REQ-016 The FSM SHALL have states IDLE, CAPTURE and DONE.
REQ-017 IDLE/DONE + start SHALL latch capture_len and clear the sample index, word count, shift register, overflow and done; the FSM SHALL then enter CAPTURE, or DONE when capture_len==0.
REQ-018 A start asserted in CAPTURE SHALL be ignored.
REQ-019 CAPTURE: every cycle, nibble {read_out_I[1:0], read_out_Q[1:0]} SHALL be sampled; sample k of a word occupies bits [4k+3:4k] (first sample in LSBs).
REQ-020 The first sample SHALL be taken on the first cycle after the start edge.
REQ-021 On the edge that takes sample 7, the complete word SHALL be pushed in the same edge (the new nibble is bits [31:28]) and the word count SHALL increment.
REQ-022 Push with FIFO full and no pop SHALL drop the word, set overflow, and still increment the word count.
REQ-023 Push with FIFO full and a simultaneous accepted pop SHALL succeed; level SHALL stay DEPTH.
REQ-024 When the word count reaches the latched capture_len, the FSM SHALL enter DONE on that edge; busy=0 and done=1 from the next cycle.
REQ-025 A pop SHALL occur iff rd_en && rd_valid; rd_en while empty SHALL have no effect.
REQ-026 A simultaneous push and pop with the FIFO neither empty nor full SHALL leave level unchanged.
REQ-027 rd_data SHALL be stable while rd_valid=1 and no pop occurs.
REQ-028 Starting a new capture SHALL NOT flush the FIFO.
REQ-029 Word count and pointers SHALL wrap modulo their widths without corrupting state.

Reset
REQ-030 rstb=0 at an edge SHALL set state=IDLE, level=0, rd_valid=0, busy=0, done=0 and overflow=0, and SHALL clear the shift register, counters and pointers.
REQ-031 rd_data after reset SHALL be 32'h0.
REQ-032 A reset mid-capture SHALL discard the partial word and all FIFO contents; no push SHALL occur on the reset edge.

Structure
REQ-033 Package unison_capture_pkg SHALL hold: the state enum; constants NIB_W=4, WORD_W=32, SAMPLES_PER_WORD=8; capture_len width 16.
REQ-034 FIFO storage SHALL be a separate sub-module, unison_sync_fifo, parameterized by DEPTH and WORD_W; the FSM and packer stay in the top module.

Verification
REQ-035 Stimulus: capture_len=1; nibbles 0..7 on consecutive cycles. Required: one word, rd_data=32'h76543210; done=1 nine cycles after start; level=1.
REQ-036 Stimulus: capture_len=10, DEPTH=8, rd_en=0. Required: level=8; words 9 and 10 dropped; overflow=1; the first 8 words are intact and in order.
REQ-037 Stimulus: capture_len=10, DEPTH=8, rd_en=1 held throughout. Required: overflow=0; all 10 words read in order; level≤1.
REQ-038 Stimulus: capture_len=0. Required: done=1 the cycle after start; no push occurs.
REQ-039 Stimulus: rstb=0 after sample 4 of word 2. Required: next cycle state=IDLE, level=0, rd_valid=0; the next capture's first word contains only new samples.
REQ-040 Stimulus: start re-asserted mid-capture; then start in DONE with the FIFO holding 3 words. Required: the mid-capture start is ignored; the restart preserves the 3 words and clears done and overflow.
